// File: rtl/dma_reg_arbiter_if.sv
// Requester-fabric / DMA-register-port bundle for dma_reg_arbiter.
// req_lock exists only when DMA_ARB_LOCK_EN is defined.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

interface dma_reg_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DW      = `DATA_WIDTH,
  parameter int AW      = `ADDR_WIDTH
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    req_we;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_wdata;
`ifdef DMA_ARB_LOCK_EN
  logic [NUM_REQ-1:0]    req_lock;
`endif
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [DW-1:0]         rsp_rdata;
  logic                  wr_en;
  logic                  rd_en;
  logic [DW-1:0]         wdata;
  logic [AW-1:0]         addr;
  logic [DW-1:0]         rdata;

`ifdef DMA_ARB_LOCK_EN
  modport slave (
    input  req, req_we, req_addr, req_wdata, req_lock, rdata,
    output gnt, rsp_valid, rsp_rdata, wr_en, rd_en, wdata, addr
  );
  modport master (
    output req, req_we, req_addr, req_wdata, req_lock, rdata,
    input  gnt, rsp_valid, rsp_rdata, wr_en, rd_en, wdata, addr
  );
`else
  modport slave (
    input  req, req_we, req_addr, req_wdata, rdata,
    output gnt, rsp_valid, rsp_rdata, wr_en, rd_en, wdata, addr
  );
  modport master (
    output req, req_we, req_addr, req_wdata, rdata,
    input  gnt, rsp_valid, rsp_rdata, wr_en, rd_en, wdata, addr
  );
`endif
endinterface

// File: rtl/dma_reg_arbiter.sv
// Round-robin arbiter sequencing single reads/writes from NUM_REQ masters onto one DMA register port.
// Define DMA_ARB_LOCK_EN to let a winner holding req_lock keep the port for atomic sequences.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module dma_reg_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int RD_LAT  = 1,
  parameter int DW      = `DATA_WIDTH,
  parameter int AW      = `ADDR_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  dma_reg_arbiter_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_RDWAIT = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [IW-1:0]      rr_last_q, rr_last_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic               wr_en_q, wr_en_d;
  logic               rd_en_q, rd_en_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [AW-1:0]      addr_q, addr_d;
`ifdef DMA_ARB_LOCK_EN
  logic               lock_q, lock_d;
`endif

  logic [NUM_REQ-1:0][AW-1:0] addr_v;
  logic [NUM_REQ-1:0][DW-1:0] wdata_v;
  logic [IW-1:0]              win;
  logic                       win_vld;

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_v[g]  = bus.req_addr[g*AW +: AW];
      assign wdata_v[g] = bus.req_wdata[g*DW +: DW];
    end
  endgenerate

  // Scan from rr_last+1 with wrap; descending loop so the nearest requester wins.
  always_comb begin
    int idx;
    idx     = 0;
    win     = rr_last_q;
    win_vld = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(rr_last_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.req[IW'(idx)]) begin
        win     = IW'(idx);
        win_vld = 1'b1;
      end
    end
`ifdef DMA_ARB_LOCK_EN
    if (lock_q && bus.req[rr_last_q]) begin
      win     = rr_last_q;
      win_vld = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
`ifdef DMA_ARB_LOCK_EN
    lock_d      = lock_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef DMA_ARB_LOCK_EN
        if (lock_q && !bus.req[rr_last_q]) lock_d = 1'b0;
`endif
        if (win_vld) begin
          gnt_d[win] = 1'b1;
          wr_en_d    = bus.req_we[win];
          rd_en_d    = !bus.req_we[win];
          addr_d     = addr_v[win];
          wdata_d    = wdata_v[win];
          rr_last_d  = win;
          state_d    = S_ISSUE;
`ifdef DMA_ARB_LOCK_EN
          lock_d     = bus.req_lock[win];
`endif
        end
      end
      S_ISSUE: begin
        // Strobes and gnt are single-cycle; only reads need the response wait.
        if (wr_en_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RDWAIT;
          cnt_d   = CW'(RD_LAT - 1);
        end
      end
      S_RDWAIT: begin
        if (cnt_q == '0) begin
          rsp_rdata_d              = bus.rdata;
          rsp_valid_d[rr_last_q]   = 1'b1;
          state_d                  = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_last_q   <= IW'(NUM_REQ - 1);
      cnt_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      wdata_q     <= '0;
      addr_q      <= '0;
`ifdef DMA_ARB_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
`ifdef DMA_ARB_LOCK_EN
      lock_q      <= lock_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.wdata     = wdata_q;
  assign bus.addr      = addr_q;
endmodule

// File: tb/tb_dma_reg_arbiter.sv
// Bench for dma_reg_arbiter: directed table, corner sequences, random traffic vs transaction model.
module tb_dma_reg_arbiter;
  localparam int NUM_REQ = 4;
  localparam int RD_LAT  = 2;
  localparam int DW      = 32;
  localparam int AW      = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dma_reg_arbiter_if #(.NUM_REQ(NUM_REQ), .DW(DW), .AW(AW)) bus ();

  dma_reg_arbiter #(.NUM_REQ(NUM_REQ), .RD_LAT(RD_LAT), .DW(DW), .AW(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] dma_val(input logic [AW-1:0] a);
    return 32'hA5A5_0000 | 32'(a >> 2);
  endfunction

  // DMA register block: data valid RD_LAT cycles after rd_en is sampled, junk otherwise.
  logic [DW-1:0] pipe [RD_LAT];
  logic [15:0]   dcnt = '0;
  always @(posedge clk) begin
    dcnt    <= dcnt + 16'd1;
    pipe[0] <= bus.rd_en ? dma_val(bus.addr) : {16'hBAD0, dcnt};
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign bus.rdata = pipe[RD_LAT-1];

  // Transaction-level reference: one access in flight, RR pick when the port is free.
  function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int last);
    for (int k = 1; k <= NUM_REQ; k++)
      if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    return -1;
  endfunction

  initial begin
    longint cyc, free_cyc, rsp_cyc;
    int m_last, w, rsp_w;
    bit rsp_pend, e_wr, e_rd;
    logic [NUM_REQ-1:0] e_gnt, exp_rv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, rsp_data;
`ifdef DMA_ARB_LOCK_EN
    bit m_lock;
    m_lock = 0;
`endif
    cyc = 0; free_cyc = 0; rsp_cyc = 0; m_last = NUM_REQ - 1; rsp_w = 0; rsp_pend = 0;
    e_gnt = '0; e_wr = 0; e_rd = 0; e_addr = '0; e_wdata = '0; rsp_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_last = NUM_REQ - 1; free_cyc = cyc; rsp_pend = 0;
        e_gnt = '0; e_wr = 0; e_rd = 0;
`ifdef DMA_ARB_LOCK_EN
        m_lock = 0;
`endif
      end else begin
        chk("m_gnt", 64'(bus.gnt), 64'(e_gnt));
        chk("m_wr_en", 64'(bus.wr_en), 64'(e_wr));
        chk("m_rd_en", 64'(bus.rd_en), 64'(e_rd));
        chk("m_excl", 64'(bus.wr_en & bus.rd_en), 64'd0);
        if (e_wr || e_rd) chk("m_addr", 64'(bus.addr), 64'(e_addr));
        if (e_wr) chk("m_wdata", 64'(bus.wdata), 64'(e_wdata));
        exp_rv = '0;
        if (rsp_pend && cyc == rsp_cyc) exp_rv[rsp_w] = 1'b1;
        chk("m_rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
        if (exp_rv != '0) begin
          chk("m_rsp_rdata", 64'(bus.rsp_rdata), 64'(rsp_data));
          rsp_pend = 0;
        end
        e_gnt = '0; e_wr = 0; e_rd = 0;
        if (cyc >= free_cyc) begin
          w = rr_pick(bus.req, m_last);
`ifdef DMA_ARB_LOCK_EN
          if (m_lock && !bus.req[m_last]) m_lock = 0;
          if (m_lock) w = m_last;
`endif
          if (w >= 0) begin
            e_gnt[w] = 1'b1;
            e_wr     = bus.req_we[w];
            e_rd     = !bus.req_we[w];
            e_addr   = bus.req_addr[w*AW +: AW];
            e_wdata  = bus.req_wdata[w*DW +: DW];
            m_last   = w;
`ifdef DMA_ARB_LOCK_EN
            m_lock   = bus.req_lock[w];
`endif
            if (e_wr) free_cyc = cyc + 2;
            else begin
              free_cyc = cyc + 2 + RD_LAT;
              rsp_cyc  = cyc + 2 + RD_LAT;
              rsp_pend = 1;
              rsp_w    = w;
              rsp_data = dma_val(e_addr);
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic on, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req[i]                = on;
    bus.req_we[i]             = w;
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_wdata[i*DW +: DW] = d;
  endtask

  task automatic clear_req();
    bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
`ifdef DMA_ARB_LOCK_EN
    bus.req_lock = '0;
`endif
  endtask

  task automatic wait_gnt(input string name, output bit ok);
    ok = 0;
    for (int t = 0; t < 30 && !ok; t++) begin
      step();
      if (bus.gnt != '0) ok = 1;
    end
    chk(name, 64'(ok), 64'd1);
  endtask

  typedef struct packed {
    logic [NUM_REQ-1:0] rq;
    logic [NUM_REQ-1:0] we;
    logic [NUM_REQ-1:0] gnt;
    logic               wr;
    logic [AW-1:0]      addr;
  } vec_t;

  vec_t tbl [13];

  initial begin
    bit ok;
    // Requester i always presents address 0x40+4*i; rr_last starts at 3 after reset.
    tbl[0]  = '{4'b1111, 4'b1111, 4'b0001, 1'b1, 8'h40};
    tbl[1]  = '{4'b1111, 4'b1111, 4'b0010, 1'b1, 8'h44};
    tbl[2]  = '{4'b1111, 4'b1111, 4'b0100, 1'b1, 8'h48};
    tbl[3]  = '{4'b1111, 4'b1111, 4'b1000, 1'b1, 8'h4C};
    tbl[4]  = '{4'b1111, 4'b1111, 4'b0001, 1'b1, 8'h40};
    tbl[5]  = '{4'b1010, 4'b1111, 4'b0010, 1'b1, 8'h44};
    tbl[6]  = '{4'b1010, 4'b1111, 4'b1000, 1'b1, 8'h4C};
    tbl[7]  = '{4'b0100, 4'b1111, 4'b0100, 1'b1, 8'h48};
    tbl[8]  = '{4'b0100, 4'b1111, 4'b0100, 1'b1, 8'h48};
    tbl[9]  = '{4'b0011, 4'b0000, 4'b0001, 1'b0, 8'h40};
    tbl[10] = '{4'b0011, 4'b0000, 4'b0010, 1'b0, 8'h44};
    tbl[11] = '{4'b1001, 4'b0000, 4'b1000, 1'b0, 8'h4C};
    tbl[12] = '{4'b1111, 4'b0101, 4'b0001, 1'b1, 8'h40};

    rst_n = 1'b0;
    clear_req();
    repeat (3) step();
    chk("rst_gnt", 64'(bus.gnt), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_strobes", 64'({bus.wr_en, bus.rd_en}), 64'd0);
    chk("rst_addr_wdata", 64'({bus.addr, bus.wdata}), 64'd0);
    chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    rst_n = 1'b1;
    step();

    for (int e = 0; e < 13; e++) begin
      clear_req();
      for (int i = 0; i < NUM_REQ; i++)
        set_req(i, tbl[e].rq[i], tbl[e].we[i], 8'h40 + 8'(4 * i), $urandom);
      wait_gnt("tbl_timeout", ok);
      chk("tbl_gnt", 64'(bus.gnt), 64'(tbl[e].gnt));
      chk("tbl_strobe", 64'({bus.wr_en, bus.rd_en}), 64'({tbl[e].wr, !tbl[e].wr}));
      chk("tbl_addr", 64'(bus.addr), 64'(tbl[e].addr));
      clear_req();
      repeat (RD_LAT + 3) step();
    end

    // Lone read from requester 1: rd_en at N+1, response at N+2+RD_LAT.
    set_req(1, 1'b1, 1'b0, 8'h04, '0);
    step();
    chk("rd_gnt", 64'(bus.gnt), 64'b0010);
    chk("rd_en", 64'({bus.rd_en, bus.wr_en}), 64'b10);
    chk("rd_addr", 64'(bus.addr), 64'h04);
    clear_req();
    for (int c = 0; c < RD_LAT; c++) begin
      step();
      chk("rd_early_rsp", 64'(bus.rsp_valid), 64'd0);
    end
    step();
    chk("rd_rsp_valid", 64'(bus.rsp_valid), 64'b0010);
    chk("rd_rsp_rdata", 64'(bus.rsp_rdata), 64'hA5A5_0001);
    repeat (3) step();

    // Write arriving while a read is outstanding waits for the response.
    set_req(0, 1'b1, 1'b0, 8'h08, '0);
    step();
    chk("blk_rd_gnt", 64'(bus.gnt), 64'b0001);
    clear_req();
    set_req(1, 1'b1, 1'b1, 8'h20, 32'hCAFE_0020);
    for (int c = 0; c < RD_LAT; c++) begin
      step();
      chk("blk_no_wr", 64'(bus.wr_en), 64'd0);
    end
    step();
    chk("blk_rsp_valid", 64'(bus.rsp_valid), 64'b0001);
    chk("blk_no_wr_rsp", 64'(bus.wr_en), 64'd0);
    step();
    chk("blk_wr_gnt", 64'({bus.gnt, bus.wr_en}), 64'({4'b0010, 1'b1}));
    chk("blk_wr_data", 64'({bus.addr, bus.wdata}), 64'({8'h20, 32'hCAFE_0020}));
    clear_req();
    repeat (3) step();

    // Reset during RDWAIT drops the pending response.
    set_req(0, 1'b1, 1'b0, 8'h0C, '0);
    step();
    clear_req();
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", 64'({bus.gnt, bus.rsp_valid, bus.wr_en, bus.rd_en}), 64'd0);
    chk("mid_rst_addr", 64'({bus.addr, bus.wdata}), 64'd0);
    chk("mid_rst_rdata", 64'(bus.rsp_rdata), 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    for (int c = 0; c < RD_LAT + 4; c++) begin
      step();
      chk("post_rst_no_rsp", 64'(bus.rsp_valid), 64'd0);
    end

    // Two writers held through reset alternate every second cycle.
    rst_n = 1'b0;
    set_req(0, 1'b1, 1'b1, 8'h10, 32'hD0D0_0000);
    set_req(1, 1'b1, 1'b1, 8'h14, 32'hD1D1_0001);
    repeat (2) step();
    rst_n = 1'b1;
    for (int gi = 0; gi < 4; gi++) begin
      step();
      chk("alt_gnt", 64'(bus.gnt), (gi % 2 == 0) ? 64'b0001 : 64'b0010);
      chk("alt_addr", 64'({bus.wr_en, bus.addr}), (gi % 2 == 0) ? 64'h110 : 64'h114);
      step();
      chk("alt_gap", 64'(bus.gnt), 64'd0);
    end
    clear_req();
    repeat (3) step();

`ifdef DMA_ARB_LOCK_EN
    // Locked read then unlocked write by requester 0 before requester 1 gets in.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_req(0, 1'b1, 1'b0, 8'h30, '0);
    bus.req_lock[0] = 1'b1;
    set_req(1, 1'b1, 1'b1, 8'h34, 32'h1111_0034);
    step();
    chk("lock_gnt0", 64'({bus.gnt, bus.rd_en}), 64'({4'b0001, 1'b1}));
    set_req(0, 1'b1, 1'b1, 8'h30, 32'h0000_0030);
    bus.req_lock[0] = 1'b0;
    wait_gnt("lock_timeout1", ok);
    chk("lock_gnt1", 64'({bus.gnt, bus.wr_en}), 64'({4'b0001, 1'b1}));
    set_req(0, 1'b0, 1'b0, '0, '0);
    wait_gnt("lock_timeout2", ok);
    chk("lock_gnt2", 64'(bus.gnt), 64'b0010);
    clear_req();
    repeat (3) step();
`endif

    // Random traffic: each requester holds until granted, then re-rolls.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.gnt[i] || !bus.req[i]) begin
          if ($urandom_range(99) < 45)
            set_req(i, 1'b1, 1'($urandom_range(1)), 8'($urandom), $urandom);
          else
            set_req(i, 1'b0, 1'b0, '0, '0);
`ifdef DMA_ARB_LOCK_EN
          bus.req_lock[i] = 1'($urandom_range(1));
`endif
        end
      end
      step();
    end
    clear_req();
    repeat (RD_LAT + 6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
